sync_fifo_stage: RTL and testbench
==================================

// Module: sync_fifo_stage
// PURPOSE
//   Synchronous FIFO that buffers 4-bit data words ahead of the 4-bit D register stage.
//   A producer pushes words with Wr_En. The consumer pops them with Rd_En.
//   Rd_Data is registered and drives the downstream register's D input directly.
//   Absorbs producer bursts and flags every rejected push or pop.
// PARAMETERS
//   WIDTH  4  data word width in bits
//   DEPTH  4  number of entries; power of two, >= 2
// PORTS
//   Clk        in   1                      clock; all logic on posedge Clk
//   Rst        in   1                      synchronous reset, active-high
//   Wr_En      in   1                      push request
//   Wr_Data    in   WIDTH                  word to push
//   Rd_En      in   1                      pop request
//   Rd_Data    out  WIDTH                  popped word, registered
//   Rd_Valid   out  1                      Rd_Data updated by a pop in the previous cycle
//   Full       out  1                      Count == DEPTH
//   Empty      out  1                      Count == 0
//   Count      out  $clog2(DEPTH+1)        current occupancy
//   Overflow   out  1                      1-cycle pulse: push rejected in previous cycle
//   Underflow  out  1                      1-cycle pulse: pop rejected in previous cycle
// BEHAVIOUR
//   - Clock and reset: one clock, Clk. Rst is synchronous and active-high and is sampled on posedge Clk.
//   - Reset values: Rd_Data=0, Rd_Valid=0, Full=0, Empty=1, Count=0, Overflow=0, Underflow=0.
//     Write and read pointers reset to 0. Memory contents are not cleared.
//   - Reset mid-operation: all stored words are discarded. Rst has priority over Wr_En and Rd_En in that cycle.
//   - Push acceptance: accepted iff Wr_En && !Full, evaluated on the pre-edge state.
//     An accepted push writes mem[wptr] and advances wptr modulo DEPTH.
//   - Pop acceptance: accepted iff Rd_En && !Empty, evaluated on the pre-edge state.
//     An accepted pop loads Rd_Data <= mem[rptr] at the edge and advances rptr modulo DEPTH.
//   - Read latency: 1 cycle. Rd_Valid is 1 in the cycle after an accepted pop, otherwise 0.
//   - Rd_Data holds its last value when no pop is accepted.
//   - Simultaneous push and pop, 0 < Count < DEPTH: both accepted; Count unchanged.
//   - Simultaneous push and pop, Full: pop accepted, push rejected (Overflow next cycle). Count becomes DEPTH-1.
//   - Simultaneous push and pop, Empty: push accepted, pop rejected (Underflow next cycle). Count becomes 1.
//     There is no write-through: the pushed word becomes readable next cycle.
//   - Count: +1 on push-only, -1 on pop-only, otherwise unchanged. Never exceeds DEPTH and never goes below 0.
//   - Full, Empty and Count are registered and consistent with each other every cycle.
//   - Pointer wrap: pointers are $clog2(DEPTH) bits and wrap silently; data order is strictly FIFO across the wrap.
//   - Overflow and Underflow: registered pulses, high for exactly one cycle per rejected request.
//     Back-to-back rejected requests give back-to-back pulses.
// TESTING
//   1. Rst=1 for 2 cycles after arbitrary traffic -> Empty=1, Count=0, Rd_Valid=0, Rd_Data=0.
//   2. Push 4'h1,4'h2,4'h3,4'h4, then a 5th push 4'h5 -> Full=1, Count=4, Overflow=1 one cycle after the 5th push.
//      4'h5 is not stored.
//   3. Pop 4 times from the Full state of test 2 -> Rd_Data 1,2,3,4 each one cycle after its pop, Rd_Valid=1 each time.
//      Then Empty=1; a 5th pop gives Underflow=1 and Rd_Data stays 4'h4.
//   4. Hold Count=2 and push+pop together for 8 cycles with data 4'h6..4'hD -> Count stays 2.
//      Pointers wrap twice and output order matches input order.
//   5. Simultaneous push+pop when Full (pushed data 4'hF) -> oldest word popped, Overflow=1, Count=3.
//      Simultaneous push+pop when Empty (pushed data 4'hA) -> Underflow=1, Count=1, 4'hA read on the next pop.
//   6. Assert Rst in the same cycle as Wr_En=1 while Count=3 -> Count=0, Empty=1, Overflow=0.
//      The next pop attempt gives Underflow=1.

Source files
------------

// File: rtl/sync_fifo_stage.sv
// sync_fifo_stage: synchronous FIFO that buffers data words ahead of a
// downstream D register. Rd_Data is registered and feeds that register
// directly. Every rejected push or pop is reported as a one-cycle pulse.
module sync_fifo_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Wr_En,
    input  logic [WIDTH-1:0]           Wr_Data,
    input  logic                       Rd_En,
    output logic [WIDTH-1:0]           Rd_Data,
    output logic                       Rd_Valid,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a push is taken on an edge iff Wr_En && !Full, and a pop iff
    // Rd_En && !Empty, both judged on the state before that edge. A taken pop
    // loads Rd_Data at the edge and raises Rd_Valid for exactly the following
    // cycle. A refused request is not held or retried; it only produces an
    // Overflow/Underflow pulse in the following cycle.

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = Wr_En && !Full;
    assign pop_ok  = Rd_En && !Empty;

    // Next occupancy: simultaneous push and pop (or neither) leaves it unchanged.
    always_comb begin
        count_nxt = Count;
        if (push_ok && !pop_ok) begin
            count_nxt = Count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = Count - CW'(1);
        end
    end

    // Storage array; never cleared, reset only discards it via the pointers.
    always_ff @(posedge Clk) begin
        if (!Rst && push_ok) begin
            mem[wptr] <= Wr_Data;
        end
    end

    // Pointers, registered read port, occupancy flags and error pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr      <= '0;
            rptr      <= '0;
            Rd_Data   <= '0;
            Rd_Valid  <= 1'b0;
            Count     <= '0;
            Full      <= 1'b0;
            Empty     <= 1'b1;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr    <= rptr + AW'(1);
                Rd_Data <= mem[rptr];
            end
            Rd_Valid  <= pop_ok;
            Count     <= count_nxt;
            Full      <= (count_nxt == DEPTH_C);
            Empty     <= (count_nxt == '0);
            Overflow  <= Wr_En && Full;
            Underflow <= Rd_En && Empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_stage.sv
// tb_sync_fifo_stage: directed table-driven bench for sync_fifo_stage, with a
// hand-written push+pop wrap sequence checked against an expected queue.
module tb_sync_fifo_stage;

    logic       Clk;
    logic       Rst;
    logic       Wr_En;
    logic [3:0] Wr_Data;
    logic       Rd_En;
    logic [3:0] Rd_Data;
    logic       Rd_Valid;
    logic       Full;
    logic       Empty;
    logic [2:0] Count;
    logic       Overflow;
    logic       Underflow;

    int tests_run;
    int tests_failed;

    logic [3:0] exp_q[$];

    typedef struct {
        string      tag;
        logic       rst;
        logic       we;
        logic [3:0] wd;
        logic       re;
        logic [3:0] e_rd;
        logic       e_v;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_cnt;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    vec_t vecs[$];

    sync_fifo_stage #(.WIDTH(4), .DEPTH(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Wr_En     (Wr_En),
        .Wr_Data   (Wr_Data),
        .Rd_En     (Rd_En),
        .Rd_Data   (Rd_Data),
        .Rd_Valid  (Rd_Valid),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    // Clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic rst, input logic we,
                       input logic [3:0] wd, input logic re,
                       input logic [3:0] e_rd, input logic e_v,
                       input logic e_full, input logic e_empty,
                       input logic [2:0] e_cnt, input logic e_ovf,
                       input logic e_udf);
        vec_t v;
        v.tag = tag; v.rst = rst; v.we = we; v.wd = wd; v.re = re;
        v.e_rd = e_rd; v.e_v = e_v; v.e_full = e_full; v.e_empty = e_empty;
        v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic drive_cycle(input logic rst, input logic we,
                               input logic [3:0] wd, input logic re);
        Rst = rst; Wr_En = we; Wr_Data = wd; Rd_En = re;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_row(input int i);
        vec_t v;
        v = vecs[i];
        drive_cycle(v.rst, v.we, v.wd, v.re);
        check({v.tag, ".rd_data"},   int'(Rd_Data),   int'(v.e_rd));
        check({v.tag, ".rd_valid"},  int'(Rd_Valid),  int'(v.e_v));
        check({v.tag, ".full"},      int'(Full),      int'(v.e_full));
        check({v.tag, ".empty"},     int'(Empty),     int'(v.e_empty));
        check({v.tag, ".count"},     int'(Count),     int'(v.e_cnt));
        check({v.tag, ".overflow"},  int'(Overflow),  int'(v.e_ovf));
        check({v.tag, ".underflow"}, int'(Underflow), int'(v.e_udf));
    endtask

    int split;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        Rst = 1'b1; Wr_En = 1'b0; Wr_Data = 4'h0; Rd_En = 1'b0;

        //   tag          rst we wd    re   rd    v  f  e  cnt  o  u
        // Power-up reset and some arbitrary traffic
        add("init_rst",   1, 0, 4'h0, 0,  4'h0, 0, 0, 1, 3'd0, 0, 0);
        add("traf_push9", 0, 1, 4'h9, 0,  4'h0, 0, 0, 0, 3'd1, 0, 0);
        add("traf_pp7",   0, 1, 4'h7, 1,  4'h9, 1, 0, 0, 3'd1, 0, 0);
        add("traf_pushC", 0, 1, 4'hC, 0,  4'h9, 0, 0, 0, 3'd2, 0, 0);
        // Reset held 2 cycles, with requests present in the first
        add("rst_cyc1",   1, 1, 4'h3, 1,  4'h0, 0, 0, 1, 3'd0, 0, 0);
        add("rst_cyc2",   1, 0, 4'h0, 0,  4'h0, 0, 0, 1, 3'd0, 0, 0);
        // Fill, then reject a fifth push
        add("fill_1",     0, 1, 4'h1, 0,  4'h0, 0, 0, 0, 3'd1, 0, 0);
        add("fill_2",     0, 1, 4'h2, 0,  4'h0, 0, 0, 0, 3'd2, 0, 0);
        add("fill_3",     0, 1, 4'h3, 0,  4'h0, 0, 0, 0, 3'd3, 0, 0);
        add("fill_4",     0, 1, 4'h4, 0,  4'h0, 0, 1, 0, 3'd4, 0, 0);
        add("fill_ovf5",  0, 1, 4'h5, 0,  4'h0, 0, 1, 0, 3'd4, 1, 0);
        add("ovf_pulse",  0, 0, 4'h0, 0,  4'h0, 0, 1, 0, 3'd4, 0, 0);
        // Drain in order, then reject a fifth pop
        add("drain_1",    0, 0, 4'h0, 1,  4'h1, 1, 0, 0, 3'd3, 0, 0);
        add("drain_2",    0, 0, 4'h0, 1,  4'h2, 1, 0, 0, 3'd2, 0, 0);
        add("drain_3",    0, 0, 4'h0, 1,  4'h3, 1, 0, 0, 3'd1, 0, 0);
        add("drain_4",    0, 0, 4'h0, 1,  4'h4, 1, 0, 1, 3'd0, 0, 0);
        add("drain_udf",  0, 0, 4'h0, 1,  4'h4, 0, 0, 1, 3'd0, 0, 1);
        add("udf_pulse",  0, 0, 4'h0, 0,  4'h4, 0, 0, 1, 3'd0, 0, 0);
        split = vecs.size();
        // After the wrap sequence: FIFO holds C,D and Rd_Data is B
        add("top_1",      0, 1, 4'h1, 0,  4'hB, 0, 0, 0, 3'd3, 0, 0);
        add("top_2",      0, 1, 4'h2, 0,  4'hB, 0, 1, 0, 3'd4, 0, 0);
        add("full_pp",    0, 1, 4'hF, 1,  4'hC, 1, 0, 0, 3'd3, 1, 0);
        add("pop_D",      0, 0, 4'h0, 1,  4'hD, 1, 0, 0, 3'd2, 0, 0);
        add("pop_1",      0, 0, 4'h0, 1,  4'h1, 1, 0, 0, 3'd1, 0, 0);
        add("pop_2",      0, 0, 4'h0, 1,  4'h2, 1, 0, 1, 3'd0, 0, 0);
        add("empty_pp",   0, 1, 4'hA, 1,  4'h2, 0, 0, 0, 3'd1, 0, 1);
        add("pop_A",      0, 0, 4'h0, 1,  4'hA, 1, 0, 1, 3'd0, 0, 0);
        // Reset wins over a push while three words are stored
        add("pre_rst_3",  0, 1, 4'h3, 0,  4'hA, 0, 0, 0, 3'd1, 0, 0);
        add("pre_rst_4",  0, 1, 4'h4, 0,  4'hA, 0, 0, 0, 3'd2, 0, 0);
        add("pre_rst_5",  0, 1, 4'h5, 0,  4'hA, 0, 0, 0, 3'd3, 0, 0);
        add("rst_vs_wr",  1, 1, 4'h6, 0,  4'h0, 0, 0, 1, 3'd0, 0, 0);
        add("post_rst_rd",0, 0, 4'h0, 1,  4'h0, 0, 0, 1, 3'd0, 0, 1);
        add("post_idle",  0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 3'd0, 0, 0);

        for (int i = 0; i < split; i++) apply_row(i);

        // Wrap sequence: prefill two words, then 8 cycles of push+pop.
        exp_q.delete();
        drive_cycle(1'b0, 1'b1, 4'hE, 1'b0);
        exp_q.push_back(4'hE);
        drive_cycle(1'b0, 1'b1, 4'h5, 1'b0);
        exp_q.push_back(4'h5);
        check("wrap.prefill_count", int'(Count), 2);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] wd;
            logic [3:0] exp_rd;
            wd = 4'(6 + i);
            exp_q.push_back(wd);
            drive_cycle(1'b0, 1'b1, wd, 1'b1);
            exp_rd = exp_q.pop_front();
            check($sformatf("wrap%0d.count", i), int'(Count), 2);
            check($sformatf("wrap%0d.rd_valid", i), int'(Rd_Valid), 1);
            check($sformatf("wrap%0d.rd_data", i), int'(Rd_Data), int'(exp_rd));
            check($sformatf("wrap%0d.flags", i), int'({Full, Empty, Overflow, Underflow}), 0);
        end
        check("wrap.left", exp_q.size(), 2);

        for (int i = split; i < vecs.size(); i++) apply_row(i);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
